rr_output_arbiter: RTL

//  Parametrised round-robin arbiter for one router output port. Filters NUM_PORTS input

---
 rtl/rr_output_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rr_output_arbiter.sv
// Round-robin arbiter for one router output port, with wormhole packet locking
// and a downstream credit counter. Grants are combinational from registered state.
module rr_output_arbiter #(
  parameter int                NUM_PORTS   = 5,
  parameter int                ADDR_W      = 3,
  parameter logic [ADDR_W-1:0] OUT_ADDR    = '0,
  parameter int                SELF_PORT   = 0,
  parameter int                MAX_CREDITS = 4,
  localparam int               IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int               CRD_W       = $clog2(MAX_CREDITS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] nexthop_addr_i,
  input  logic [NUM_PORTS-1:0]        flit_valid_i,
  input  logic [NUM_PORTS-1:0]        flit_tail_i,
  input  logic                        credit_return_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        grant_valid_o,
  output logic [IDX_W-1:0]            grant_idx_o,
  output logic                        locked_o,
  output logic [CRD_W-1:0]            credit_count_o,
  output logic                        credit_err_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CRD_W-1:0]     credit_q, credit_d;
  logic                 credit_err_q, credit_err_d;

  logic [NUM_PORTS-1:0] req;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;
  int                   cand;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credit_q     <= CRD_W'(MAX_CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

  // Requests addressed to this output, excluding the U-turn input.
  always_comb begin
    req = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      req[j] = flit_valid_i[j] &&
               (nexthop_addr_i[j*ADDR_W +: ADDR_W] == OUT_ADDR) &&
               (j != SELF_PORT);
    end
  end

  // Rotating search starting at rr_ptr; the wrap is explicit so NUM_PORTS may be any value.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    credit_d     = credit_q;
    credit_err_d = 1'b0;
    if (grant_valid) begin
      if (state_q == IDLE) begin
        rr_ptr_d = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
        if (!flit_tail_i[grant_idx]) begin
          state_d = LOCKED;
          owner_d = grant_idx;
        end
      end else if (flit_tail_i[grant_idx]) begin
        state_d = IDLE;
      end
    end
    case ({grant_valid, credit_return_i})
      2'b10: credit_d = credit_q - CRD_W'(1);
      2'b01: begin
        if (credit_q == CRD_W'(MAX_CREDITS)) credit_err_d = 1'b1;
        else                                 credit_d     = credit_q + CRD_W'(1);
      end
      default: ;
    endcase
  end

  // While locked only the owner may move; nothing moves without a credit or during reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_o     = '0;
    if (!reset && (credit_q != '0)) begin
      if (state_q == IDLE) begin
        grant_valid = win_found;
        grant_idx   = win_found ? win_idx : '0;
      end else if (req[owner_q]) begin
        grant_valid = 1'b1;
        grant_idx   = owner_q;
      end
    end
    if (grant_valid) grant_o[grant_idx] = 1'b1;
  end

  assign grant_valid_o  = grant_valid;
  assign grant_idx_o    = grant_idx;
  assign locked_o       = (state_q == LOCKED);
  assign credit_count_o = credit_q;
  assign credit_err_o   = credit_err_q;

endmodule
